// File: rtl/phy_tx_sched.sv
// ----------------------------------------------------------------------------
// phy_tx_sched
//   Link sequencer and two-source round-robin arbiter feeding the phy_TX
//   32-bit word input, clocked by the phy_TX word clock (clk_f).
//
//   The link is brought up OFF -> TRAIN -> RUN. It is taken down through
//   RUN -> DRAIN -> OFF. In RUN, two requesters share the PHY input under
//   round-robin arbitration. A source may keep the input for at most
//   BURST_MAX consecutive grants while the other source is also requesting.
//
// Parameters
//   IDLE_WORDS  cycles spent in TRAIN (active=1, valid=0) before RUN (1..255)
//   BURST_MAX   max consecutive grants to one source under contention (1..255)
//
// Ports
//   clk_f        in   word clock; all state changes on its rising edge
//   reset        in   asynchronous, active-high reset
//   link_enable  in   1 = bring up / keep link up, 0 = drain and shut down
//   req_0/1      in   source has a word on data_0/1
//   data_0/1     in   source words; held stable while the matching req is high
//   gnt_0/1      out  combinational grant; the word is consumed at the next edge
//   data_input   out  registered word to phy_TX
//   valid        out  registered; data_input holds a granted word
//   active       out  registered; link active to phy_TX
//   link_state   out  registered state: 0 OFF, 1 TRAIN, 2 RUN, 3 DRAIN
//   tx_count     out  registered count of words sent; wraps at 16 bits
// ----------------------------------------------------------------------------
module phy_tx_sched #(
    parameter int IDLE_WORDS = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        link_enable,
    input  logic        req_0,
    input  logic [31:0] data_0,
    input  logic        req_1,
    input  logic [31:0] data_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic [31:0] data_input,
    output logic        valid,
    output logic        active,
    output logic [1:0]  link_state,
    output logic [15:0] tx_count
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // The train counter is cleared on entry to TRAIN and counts the edges
    // already spent there. The edge that sees IDLE_WORDS-1 is the last one.
    localparam logic [7:0] TRAIN_LAST = 8'(IDLE_WORDS - 1);
    localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [7:0]  train_cnt_reg;
    logic [7:0]  burst_cnt_reg;
    logic        owner_reg;          // 0 = source 0 owns the burst, 1 = source 1
    logic [31:0] data_input_reg;
    logic        valid_reg;
    logic        active_reg;
    logic [15:0] tx_count_reg;

    // ------------------------------------------------------------------
    // Arbitration (combinational)
    // ------------------------------------------------------------------
    logic        grant_en;
    logic        any_req;
    logic        burst_full;
    logic        pick_1;             // source 1 would win if a grant is issued
    logic        xfer;
    logic [31:0] xfer_data;
    logic        owner_next;
    logic [7:0]  burst_cnt_next;

    always_comb begin
        // Reset is included so that the grants drop at once when reset
        // asserts, before the state register has been observed as OFF.
        grant_en   = (state_reg == ST_RUN) && link_enable && !reset;
        any_req    = req_0 | req_1;
        burst_full = (burst_cnt_reg >= BURST_LIM);

        // Under contention the owner keeps the input until its burst is
        // exhausted, then the other source takes over. A lone requester
        // always wins, whatever the current burst state.
        if (req_0 && req_1) begin
            pick_1 = burst_full ? ~owner_reg : owner_reg;
        end else begin
            pick_1 = req_1;
        end

        gnt_0     = grant_en && any_req && !pick_1;
        gnt_1     = grant_en && any_req &&  pick_1;
        xfer      = gnt_0 | gnt_1;
        xfer_data = gnt_1 ? data_1 : data_0;

        // Burst bookkeeping for a transfer. When the owner changes, a new
        // burst of one word starts. When it does not, the count saturates
        // at BURST_MAX so that a lone requester cannot wrap it.
        if (pick_1 != owner_reg) begin
            owner_next     = pick_1;
            burst_cnt_next = 8'd1;
        end else begin
            owner_next     = owner_reg;
            burst_cnt_next = burst_full ? burst_cnt_reg : burst_cnt_reg + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Link FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_OFF;
            train_cnt_reg  <= 8'd0;
            burst_cnt_reg  <= 8'd0;
            owner_reg      <= 1'b1;
            data_input_reg <= 32'd0;
            valid_reg      <= 1'b0;
            active_reg     <= 1'b0;
            tx_count_reg   <= 16'd0;
        end else begin
            // valid is a single-cycle marker for each transferred word.
            // data_input keeps its last value when no word is sent.
            valid_reg <= 1'b0;

            case (state_reg)
                ST_OFF: begin
                    // active tracks the state being entered, so it is
                    // already 1 on the edge that starts training.
                    if (link_enable) begin
                        state_reg     <= ST_TRAIN;
                        train_cnt_reg <= 8'd0;
                        active_reg    <= 1'b1;
                    end else begin
                        active_reg    <= 1'b0;
                    end
                end

                ST_TRAIN: begin
                    if (!link_enable) begin
                        state_reg  <= ST_OFF;
                        active_reg <= 1'b0;
                    end else begin
                        active_reg    <= 1'b1;
                        train_cnt_reg <= train_cnt_reg + 8'd1;
                        if (train_cnt_reg == TRAIN_LAST) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    active_reg <= 1'b1;
                    if (!link_enable) begin
                        // grant_en is already low, so no word is taken here.
                        state_reg <= ST_DRAIN;
                    end else if (xfer) begin
                        data_input_reg <= xfer_data;
                        valid_reg      <= 1'b1;
                        tx_count_reg   <= tx_count_reg + 16'd1;
                        owner_reg      <= owner_next;
                        burst_cnt_reg  <= burst_cnt_next;
                    end
                end

                ST_DRAIN: begin
                    // One quiet active cycle, then off regardless of
                    // link_enable. Re-enabling restarts training from OFF.
                    state_reg  <= ST_OFF;
                    active_reg <= 1'b0;
                end

                default: begin
                    state_reg  <= ST_OFF;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign data_input = data_input_reg;
    assign valid      = valid_reg;
    assign active     = active_reg;
    assign link_state = state_reg;
    assign tx_count   = tx_count_reg;

endmodule

// File: tb/tb_phy_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_phy_tx_sched
//   Self-checking bench for phy_tx_sched (IDLE_WORDS=4, BURST_MAX=8).
//   A behavioural link/arbiter model advances on each rising edge. At every
//   falling edge one compare process checks all DUT outputs against it.
//   Directed phases add literal expectations for bring-up, streaming,
//   burst alternation, shutdown, async reset and counter wrap. A random
//   phase runs in between.
// ----------------------------------------------------------------------------
module tb_phy_tx_sched;

    localparam int IDLE_WORDS = 4;
    localparam int BURST_MAX  = 8;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic        link_enable = 1'b0;
    logic        req_0 = 1'b0;
    logic [31:0] data_0 = 32'd0;
    logic        req_1 = 1'b0;
    logic [31:0] data_1 = 32'd0;
    logic        gnt_0;
    logic        gnt_1;
    logic [31:0] data_input;
    logic        valid;
    logic        active;
    logic [1:0]  link_state;
    logic [15:0] tx_count;

    phy_tx_sched #(
        .IDLE_WORDS(IDLE_WORDS),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .link_enable(link_enable),
        .req_0      (req_0),
        .data_0     (data_0),
        .req_1      (req_1),
        .data_1     (data_1),
        .gnt_0      (gnt_0),
        .gnt_1      (gnt_1),
        .data_input (data_input),
        .valid      (valid),
        .active     (active),
        .link_state (link_state),
        .tx_count   (tx_count)
    );

    always #5 clk_f = ~clk_f;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model.
    //   mode: 0 off, 1 training, 2 running, 3 draining
    //   trained: cycles already completed in training
    //   owner/burst: whose burst is running and how many words it has had
    // ------------------------------------------------------------------
    int          m_mode;
    int          m_trained;
    int          m_owner;
    int          m_burst;
    int          m_count;
    logic [31:0] m_data;
    bit          m_valid;

    function automatic void model_reset();
        m_mode    = 0;
        m_trained = 0;
        m_owner   = 1;
        m_burst   = 0;
        m_count   = 0;
        m_data    = 32'd0;
        m_valid   = 1'b0;
    endfunction

    // Which source is served now: -1 none, 0 or 1.
    function automatic int model_pick();
        if (reset || m_mode != 2 || !link_enable) return -1;
        if (req_0 && req_1) return (m_burst >= BURST_MAX) ? 1 - m_owner : m_owner;
        if (req_0) return 0;
        if (req_1) return 1;
        return -1;
    endfunction

    function automatic void model_edge();
        int w;
        w = model_pick();
        m_valid = 1'b0;
        case (m_mode)
            0: if (link_enable) begin m_mode = 1; m_trained = 0; end
            1: begin
                if (!link_enable) m_mode = 0;
                else begin
                    m_trained++;
                    if (m_trained == IDLE_WORDS) m_mode = 2;
                end
            end
            2: begin
                if (!link_enable) m_mode = 3;
                else if (w >= 0) begin
                    m_valid = 1'b1;
                    m_data  = (w == 1) ? data_1 : data_0;
                    m_count = (m_count + 1) % 65536;
                    if (w == m_owner) begin
                        if (m_burst < BURST_MAX) m_burst++;
                    end else begin
                        m_owner = w;
                        m_burst = 1;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endfunction

    // Inputs change only at posedge+1 (or, for reset, away from both edges).
    // The model can therefore read them race-free on the rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk_f);
            if (!reset) model_edge();
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    bit g0_seen = 1'b0;
    bit g1_seen = 1'b0;

    initial begin
        int w;
        forever begin
            @(negedge clk_f);
            g0_seen = gnt_0;
            g1_seen = gnt_1;
            if (reset) model_reset();
            w = model_pick();
            check("gnt_0",      32'(gnt_0),      32'(w == 0));
            check("gnt_1",      32'(gnt_1),      32'(w == 1));
            check("data_input", data_input,      m_data);
            check("valid",      32'(valid),      32'(m_valid));
            check("active",     32'(active),     32'(m_mode != 0));
            check("link_state", 32'(link_state), 32'(m_mode));
            check("tx_count",   32'(tx_count),   32'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (link_state != 2'd2 && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(link_state), 32'd2);
    endtask

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int c1;
        bit exp1;

        // 1: bring-up from reset with link_enable high from t0
        reset = 1'b1;
        link_enable = 1'b1;
        #12 reset = 1'b0;
        tick();
        check("t1_active_edge1", 32'(active), 32'd1);
        check("t1_state_edge1",  32'(link_state), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t1_valid_train", 32'(valid), 32'd0);
            check("t1_state_train", 32'(link_state), 32'd1);
        end
        tick();
        check("t1_state_edge5", 32'(link_state), 32'd2);
        check("t1_valid_edge5", 32'(valid), 32'd0);

        // 2: single source streams A0..A9 back-to-back
        for (int i = 0; i < 10; i++) begin
            req_0  = 1'b1;
            data_0 = 32'hA000_0000 + 32'(i);
            #1;
            check("t2_gnt_0", 32'(gnt_0), 32'd1);
            tick();
            check("t2_data", data_input, 32'hA000_0000 + 32'(i));
            check("t2_valid", 32'(valid), 32'd1);
        end
        req_0 = 1'b0;
        check("t2_tx_count", 32'(tx_count), 32'd10);

        // 3: both requesting. Source 0 holds a full burst, so the pattern
        //    is 1x8, 0x8, 1x8.
        c0 = 0;
        c1 = 0;
        req_0 = 1'b1;  data_0 = 32'hB000_0000;
        req_1 = 1'b1;  data_1 = 32'hC000_0000;
        for (int i = 0; i < 24; i++) begin
            #1;
            exp1 = ((i / 8) % 2) == 0;
            check("t3_gnt_1", 32'(gnt_1), 32'(exp1));
            check("t3_gnt_0", 32'(gnt_0), 32'(!exp1));
            tick();
            check("t3_valid", 32'(valid), 32'd1);
            if (exp1) begin c1++; data_1 = 32'hC000_0000 + 32'(c1); end
            else      begin c0++; data_0 = 32'hB000_0000 + 32'(c0); end
        end

        // 4: shutdown while streaming
        req_1 = 1'b0;
        req_0 = 1'b1;
        data_0 = 32'hD000_0000;
        tick();
        data_0 = 32'hD000_0001;
        link_enable = 1'b0;
        #1;
        check("t4_gnt_0_off", 32'(gnt_0), 32'd0);
        check("t4_gnt_1_off", 32'(gnt_1), 32'd0);
        tick();
        check("t4_valid",  32'(valid), 32'd0);
        check("t4_state3", 32'(link_state), 32'd3);
        check("t4_active1", 32'(active), 32'd1);
        tick();
        check("t4_state0",  32'(link_state), 32'd0);
        check("t4_active0", 32'(active), 32'd0);
        req_0 = 1'b0;

        // Random traffic with occasional link drops. The model checks it.
        link_enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!req_0 || g0_seen) begin
                req_0  = ($urandom_range(0, 3) != 0);
                data_0 = $urandom;
            end
            if (!req_1 || g1_seen) begin
                req_1  = ($urandom_range(0, 3) != 0);
                data_1 = $urandom;
            end
            if (link_enable) begin
                if ($urandom_range(0, 99) == 0) link_enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                link_enable = 1'b1;
            end
            tick();
        end

        // 6: async reset pulse mid-burst, then re-train
        link_enable = 1'b1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();
        wait_run("t6_reach_run");
        req_0 = 1'b1;
        req_1 = 1'b1;
        data_0 = 32'h6000_0000;
        data_1 = 32'h6100_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (g0_seen) data_0 = data_0 + 32'd1;
            if (g1_seen) data_1 = data_1 + 32'd1;
        end
        #1 reset = 1'b1;
        #1;
        check("t6_data0",   data_input, 32'd0);
        check("t6_valid0",  32'(valid), 32'd0);
        check("t6_active0", 32'(active), 32'd0);
        check("t6_state0",  32'(link_state), 32'd0);
        check("t6_count0",  32'(tx_count), 32'd0);
        check("t6_gnt0",    32'({gnt_1, gnt_0}), 32'd0);
        @(negedge clk_f);
        #1 reset = 1'b0;
        tick();
        check("t6_retrain_state1", 32'(link_state), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t6_retrain_train", 32'(link_state), 32'd1);
        end
        tick();
        check("t6_retrain_run", 32'(link_state), 32'd2);
        req_0 = 1'b0;
        req_1 = 1'b0;

        // 5: tx_count wrap after 65534 + 3 words
        reset = 1'b1;
        @(negedge clk_f);
        #1 reset = 1'b0;
        link_enable = 1'b1;
        wait_run("t5_reach_run");
        req_0 = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            data_0 = 32'(i);
            tick();
        end
        check("t5_count_fffe", 32'(tx_count), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            data_0 = 32'h5500_0000 + 32'(i);
            tick();
        end
        check("t5_count_wrap", 32'(tx_count), 32'h0000_0001);
        check("t5_last_data", data_input, 32'h5500_0002);
        req_0 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
